// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into short, long and double press strobes plus a held flag.
// Optional auto-repeat of long_press while held: define BUTTON_AUTO_REPEAT_EN.
module button_event_decoder #(
  parameter int LONG_TIME   = 10_000_000,
  parameter int DOUBLE_GAP  = 3_000_000,
  parameter int REPEAT_TIME = 2_000_000,
  parameter int COUNTER_LEN = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_level,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic held
);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    LONG_HELD      = 3'd2,
    WAIT_SECOND    = 3'd3,
    SECOND_PRESSED = 3'd4
  } state_t;

  localparam int MAX_AB   = (LONG_TIME > DOUBLE_GAP) ? LONG_TIME : DOUBLE_GAP;
  localparam int MAX_TIME = (MAX_AB > REPEAT_TIME) ? MAX_AB : REPEAT_TIME;

  // Refuse to elaborate with a counter too narrow for the longest threshold.
  if ((MAX_TIME >> COUNTER_LEN) != 0) begin : g_width_check
    $error("COUNTER_LEN too small for the configured thresholds");
  end

  localparam logic [COUNTER_LEN-1:0] LONG_LAST   = COUNTER_LEN'(LONG_TIME - 1);
  localparam logic [COUNTER_LEN-1:0] DOUBLE_LAST = COUNTER_LEN'(DOUBLE_GAP - 1);
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [COUNTER_LEN-1:0] REPEAT_LAST = COUNTER_LEN'(REPEAT_TIME - 1);
`endif

  state_t                 state;
  logic [COUNTER_LEN-1:0] counter;
  logic                   btn_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      counter      <= '0;
      btn_prev     <= 1'b1;  // a button held through reset must be released first
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      held         <= 1'b0;
    end else begin
      btn_prev     <= btn_level;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      case (state)
        IDLE: begin
          held    <= 1'b0;
          counter <= '0;
          if (btn_level && !btn_prev) begin
            state <= PRESSED;
          end
        end
        PRESSED: begin
          // Release takes priority over reaching the long-press threshold.
          if (!btn_level) begin
            state   <= WAIT_SECOND;
            counter <= '0;
          end else if (counter >= LONG_LAST) begin
            state      <= LONG_HELD;
            counter    <= '0;
            long_press <= 1'b1;
            held       <= 1'b1;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        LONG_HELD: begin
          if (!btn_level) begin
            state   <= IDLE;
            counter <= '0;
            held    <= 1'b0;
          end
`ifdef BUTTON_AUTO_REPEAT_EN
          else if (counter >= REPEAT_LAST) begin
            counter    <= '0;
            long_press <= 1'b1;
          end else begin
            counter <= counter + 1'b1;
          end
`endif
        end
        WAIT_SECOND: begin
          // A second press takes priority over the gap timeout.
          if (btn_level) begin
            state   <= SECOND_PRESSED;
            counter <= '0;
          end else if (counter >= DOUBLE_LAST) begin
            state       <= IDLE;
            counter     <= '0;
            short_press <= 1'b1;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        SECOND_PRESSED: begin
          if (!btn_level) begin
            state        <= IDLE;
            counter      <= '0;
            double_press <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          counter <= '0;
          held    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder: expected strobes are queued with their cycle
// when stimulus is driven and matched as the DUT emits them.
module tb_button_event_decoder;

  localparam int LT = 20;
  localparam int DG = 8;
  localparam int RT = 5;

  logic clk = 1'b0;
  logic reset;
  logic btn_level;
  logic short_press;
  logic long_press;
  logic double_press;
  logic held;

  always #5 clk = ~clk;

  button_event_decoder #(
    .LONG_TIME(LT),
    .DOUBLE_GAP(DG),
    .REPEAT_TIME(RT),
    .COUNTER_LEN(24)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_level(btn_level),
    .short_press(short_press),
    .long_press(long_press),
    .double_press(double_press),
    .held(held)
  );

  typedef struct {
    int kind;  // 0 short, 1 long, 2 double
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    int   n;
    int   kind;
    ev_t  e;
    n = int'(short_press) + int'(long_press) + int'(double_press);
    if (n != 0) begin
      checks++;
      kind = short_press ? 0 : (long_press ? 1 : 2);
      if (n > 1) begin
        errors++;
        $display("FAIL one_strobe: %0d strobes at cycle %0d, required 1", n, edge_cnt);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: kind %0d at cycle %0d, required none", kind, edge_cnt);
      end else begin
        e = exp_q.pop_front();
        if (e.kind !== kind || e.cyc !== edge_cnt) begin
          errors++;
          $display("FAIL event_match: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                   kind, edge_cnt, e.kind, e.cyc);
        end else begin
          $display("ok event kind %0d at cycle %0d", kind, edge_cnt);
        end
      end
    end
  end

  task automatic push(input int kind, input int cyc);
    ev_t e;
    e.kind = kind;
    e.cyc  = cyc;
    exp_q.push_back(e);
  endtask

  // First long_press at entry+LT; with auto-repeat, further ones every RT until release edge r.
  task automatic push_long(input int p, input int r);
    push(1, p + LT);
`ifdef BUTTON_AUTO_REPEAT_EN
    for (int t = p + LT + RT; t < r; t += RT) push(1, t);
`endif
  endtask

  task automatic hold(input logic lvl, input int n);
    btn_level = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_held(input string name, input logic req);
    checks++;
    if (held !== req) begin
      errors++;
      $display("FAIL %s: held=%b, required %b", name, held, req);
    end else begin
      $display("ok %s held=%b", name, held);
    end
  endtask

  task automatic finish_test(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: %0d events pending, required 0", name, exp_q.size());
      exp_q.delete();
    end else begin
      $display("ok %s all events seen", name);
    end
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    btn_level = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({short_press, long_press, double_press, held} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: %b, required 0000",
               {short_press, long_press, double_press, held});
    end else begin
      $display("ok reset outputs zero");
    end
    reset = 1'b0;
    hold(1'b0, 2);
  endtask

  task automatic test_short;
    int r;
    hold(1'b1, 5);
    r = edge_cnt + 1;
    push(0, r + DG);
    hold(1'b0, DG + 6);
    finish_test("short");
  endtask

  task automatic test_double;
    int r2;
    hold(1'b1, 5);
    hold(1'b0, 3);
    hold(1'b1, 4);
    r2 = edge_cnt + 1;
    push(2, r2);
    hold(1'b0, DG + 6);
    finish_test("double");
  endtask

  task automatic test_long;
    int p;
    p = edge_cnt + 1;
    push_long(p, p + 30);
    hold(1'b1, LT);
    check_held("long_before", 1'b0);
    hold(1'b1, 1);
    check_held("long_at_threshold", 1'b1);
    hold(1'b1, 30 - LT - 1);
    check_held("long_still_held", 1'b1);
    hold(1'b0, 1);
    check_held("long_released", 1'b0);
    hold(1'b0, DG + 4);
    finish_test("long");
  endtask

  task automatic test_held_through_reset;
    int r;
    reset = 1'b1;
    hold(1'b1, 3);
    reset = 1'b0;
    hold(1'b1, 40);
    check_held("ignored_hold", 1'b0);
    hold(1'b0, 3);
    hold(1'b1, 5);
    r = edge_cnt + 1;
    push(0, r + DG);
    hold(1'b0, DG + 6);
    finish_test("held_through_reset");
  endtask

  task automatic test_reset_wait;
    hold(1'b1, 5);
    hold(1'b0, 4);
    reset = 1'b1;
    #1;
    checks++;
    if ({short_press, long_press, double_press, held} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_wait_outputs: %b, required 0000",
               {short_press, long_press, double_press, held});
    end else begin
      $display("ok reset in wait_second outputs zero");
    end
    @(negedge clk);
    reset = 1'b0;
    hold(1'b0, DG + 6);
    finish_test("reset_wait");
  endtask

  task automatic test_reset_long_held;
    int p;
    p = edge_cnt + 1;
    push_long(p, p + LT + 2);
    hold(1'b1, LT + 1);
    check_held("pre_reset_held", 1'b1);
    reset = 1'b1;
    #1;
    check_held("async_held_drop", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    hold(1'b1, 10);
    hold(1'b0, 3);
    finish_test("reset_long_held");
  endtask

  task automatic test_boundary_release;
    int r;
    hold(1'b1, LT);
    r = edge_cnt + 1;
    push(0, r + DG);
    hold(1'b0, DG + 6);
    finish_test("boundary_release");
  endtask

  // With auto-repeat: long_press at 20, 25, 30, 35; otherwise only at 20.
  task automatic test_hold36;
    int p;
    p = edge_cnt + 1;
    push_long(p, p + 36);
    hold(1'b1, 36);
    hold(1'b0, DG + 4);
    finish_test("hold36");
  endtask

  initial begin
    test_reset();
    test_short();
    test_double();
    test_long();
    test_held_through_reset();
    test_reset_wait();
    test_reset_long_held();
    test_boundary_release();
    test_hold36();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
